// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types for the two-requester APB command arbiter
package apb_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int ARB_DW  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Field widths are fixed at ARB_DW; the arbiter's DW must match.
  typedef struct packed {
    logic              write;
    logic [1:0]        sel;
    logic [ARB_DW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
    logic [ARB_DW-1:0] wait_cycles;
  } arb_cmd_t;

endpackage

// File: rtl/rr_grant2.sv
// rtl/rr_grant2.sv - combinational two-way round-robin picker
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);

  assign valid = |req;

  // On contention the requester that did not win last time goes next.
  always_comb begin
    idx = 1'b0;
    case (req)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = ~last;
      default: idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/apb_request_arbiter.sv
// rtl/apb_request_arbiter.sv - shares one APB_Master command port between two requesters
// Optional WAIT watchdog is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_request_arbiter
  import apb_arb_pkg::*;
#(
  parameter int DW             = ARB_DW,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ-1:0][1:0]    req_sel,
  input  logic [NUM_REQ-1:0][DW-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DW-1:0] req_wdata,
  input  logic [NUM_REQ-1:0][DW-1:0] req_wait_cycles,
  output logic [NUM_REQ-1:0]         done,
  output logic [DW-1:0]              resp_rdata,
  output logic                       resp_err,
  output logic                       grant,
  output logic                       busy,
  output logic                       start,
  output logic                       write,
  output logic [1:0]                 sel,
  output logic [DW-1:0]              addr,
  output logic [DW-1:0]              wdata,
  output logic [DW-1:0]              wait_cycles,
  input  logic                       stable,
  input  logic [DW-1:0]              rdata
);

  arb_state_t    state_q, state_d;
  arb_cmd_t      cmd_q, cmd_d;
  logic          grant_q, grant_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          pick_valid;
  logic          pick_idx;

  rr_grant2 u_pick (
    .req   (req),
    .last  (grant_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_err_q, resp_err_d;
  logic             expired;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    grant_d      = grant_q;
    resp_rdata_d = resp_rdata_q;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    resp_err_d   = resp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d           = pick_idx;
          cmd_d.write       = req_write[pick_idx];
          cmd_d.sel         = req_sel[pick_idx];
          cmd_d.addr        = req_addr[pick_idx];
          cmd_d.wdata       = req_wdata[pick_idx];
          cmd_d.wait_cycles = req_wait_cycles[pick_idx];
          state_d           = ISSUE;
        end
      end
      // stable is deliberately not looked at here: it may be left over from the previous transfer.
      ISSUE: begin
        state_d = WAIT;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (stable) begin
          resp_rdata_d = rdata;
          state_d      = DONE;
`ifdef APB_ARB_TIMEOUT_EN
          resp_err_d   = 1'b0;
        end else if (expired) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      grant_q      <= 1'b1;
      resp_rdata_q <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      grant_q      <= grant_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign done        = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy        = (state_q != IDLE);
  assign start       = (state_q == ISSUE);
  assign grant       = grant_q;
  assign resp_rdata  = resp_rdata_q;
  assign write       = cmd_q.write;
  assign sel         = cmd_q.sel;
  assign addr        = cmd_q.addr;
  assign wdata       = cmd_q.wdata;
  assign wait_cycles = cmd_q.wait_cycles;
`ifdef APB_ARB_TIMEOUT_EN
  assign resp_err    = resp_err_q;
`else
  assign resp_err    = 1'b0;
`endif

endmodule
